// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared defaults, response record and grant-state encoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

  localparam int unsigned DMEM_DEPTH_WORDS = 4096;
  localparam logic [31:0] DMEM_BASE_ADDR   = 32'h0001_0000;
  localparam int          DMEM_RESP_LAT    = 1;
  localparam int          DMEM_GNT_STALL   = 0;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] rdata;
  } dmem_resp_t;

  typedef enum logic [0:0] {
    GNT_IDLE = 1'b0,
    GNT_WAIT = 1'b1
  } gnt_state_e;

  // Underflow is caught by the explicit compare, so the wrapped offset never aliases.
  function automatic logic dmem_access_err(input logic [31:0] addr, input logic [3:0] be,
                                           input logic [31:0] base, input int unsigned depth);
    logic [31:0] word;
    word = (addr - base) >> 2;
    return (addr < base) || (word >= depth) || (be == 4'b0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module      : dmem_responder_if
// Description : Core data bus: req/gnt request handshake plus valid/error response.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;

  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        data_error;

  modport master (
    output data_req, data_wr, data_addr, data_wdata, data_be,
    input  data_gnt, data_rdata, data_valid, data_error
  );

  modport slave (
    input  data_req, data_wr, data_addr, data_wdata, data_be,
    output data_gnt, data_rdata, data_valid, data_error
  );

endinterface

`default_nettype wire

// File: rtl/dmem_sram.sv
// ============================================================================
// Module      : dmem_sram
// Description : Single-port DEPTH_WORDS x 32 SRAM, synchronous read, byte-lane write.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dmem_sram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int          ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Data-bus responder with byte-addressable SRAM, optional grant
//               stall and fixed-latency response pipe.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          RESP_LAT    = DMEM_RESP_LAT,
  parameter int          GNT_STALL   = DMEM_GNT_STALL
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_responder_if.slave  bus
);

  localparam int c_addr_w = $clog2(DEPTH_WORDS);

  logic                w_gnt;
  logic                w_err;
  logic [c_addr_w-1:0] w_idx;
  logic [31:0]         w_sram_q;
  logic                r_s0_vld;
  logic                r_s0_err;
  logic                r_s0_load;
  dmem_resp_t          w_s0;
  dmem_resp_t          w_out;

  assign w_err = dmem_access_err(bus.data_addr, bus.data_be, BASE_ADDR, DEPTH_WORDS);
  assign w_idx = c_addr_w'((bus.data_addr - BASE_ADDR) >> 2);

  if (GNT_STALL == 0) begin : g_no_stall
    assign w_gnt = bus.data_req;
  end else begin : g_stall
    localparam logic [2:0] c_stall = 3'(GNT_STALL);

    gnt_state_e r_state;
    logic [2:0] r_cnt;

    // A request dropped while waiting abandons the stall without a grant.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= GNT_IDLE;
        r_cnt   <= 3'd0;
      end else begin
        case (r_state)
          GNT_IDLE: begin
            if (bus.data_req) begin
              r_state <= GNT_WAIT;
              r_cnt   <= 3'd1;
            end
          end
          GNT_WAIT: begin
            if (!bus.data_req || (r_cnt == c_stall)) begin
              r_state <= GNT_IDLE;
              r_cnt   <= 3'd0;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
          default: begin
            r_state <= GNT_IDLE;
            r_cnt   <= 3'd0;
          end
        endcase
      end
    end

    assign w_gnt = (r_state == GNT_WAIT) && bus.data_req && (r_cnt == c_stall);
  end

  assign bus.data_gnt = w_gnt;

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (c_addr_w)
  ) u_sram (
    .clk   (clk),
    .en    (w_gnt & ~w_err),
    .we    (bus.data_wr),
    .be    (bus.data_be),
    .addr  (w_idx),
    .wdata (bus.data_wdata),
    .rdata (w_sram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0_vld  <= 1'b0;
      r_s0_err  <= 1'b0;
      r_s0_load <= 1'b0;
    end else begin
      r_s0_vld  <= w_gnt;
      r_s0_err  <= w_gnt & w_err;
      r_s0_load <= w_gnt & ~w_err & ~bus.data_wr;
    end
  end

  // The SRAM read register is the first pipe stage's data; only good loads expose it.
  assign w_s0 = '{vld: r_s0_vld, err: r_s0_err, rdata: (r_s0_load ? w_sram_q : 32'h0)};

  if (RESP_LAT == 1) begin : g_lat1
    assign w_out = w_s0;
  end else begin : g_latn
    dmem_resp_t r_pipe [RESP_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < RESP_LAT - 1; i++) begin
          r_pipe[i] <= '0;
        end
      end else begin
        r_pipe[0] <= w_s0;
        for (int i = 1; i < RESP_LAT - 1; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign w_out = r_pipe[RESP_LAT-2];
  end

  assign bus.data_valid = w_out.vld;
  assign bus.data_error = w_out.err;
  assign bus.data_rdata = w_out.rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Three responder configurations driven from a vector table with a
//               response scoreboard, plus stall-abort and mid-flight reset sequences.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    int          d;
    int          cyc;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        req   [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic        gnt   [3];
  logic        valid [3];
  logic        error [3];
  logic [31:0] rdata [3];

  vec_t        tbl [$];
  exp_t        q [$];
  int          n_chk;
  int          n_fail;
  int          cyc;
  int          cur_d;
  logic        pend_err;
  logic [31:0] pend_rd;
  logic        saw_gnt;
  int          vseen [3];

  // DUT 0: latency 1, no stall. DUT 1: latency 3, no stall. DUT 2: latency 1, stall 2.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder_if bus ();
    assign bus.data_req   = req[g];
    assign bus.data_wr    = wr[g];
    assign bus.data_addr  = addr[g];
    assign bus.data_wdata = wdata[g];
    assign bus.data_be    = be[g];
    assign gnt[g]   = bus.data_gnt;
    assign valid[g] = bus.data_valid;
    assign error[g] = bus.data_error;
    assign rdata[g] = bus.data_rdata;

    dmem_responder #(
      .DEPTH_WORDS (4096),
      .BASE_ADDR   (32'h0001_0000),
      .RESP_LAT    ((g == 1) ? 3 : 1),
      .GNT_STALL   ((g == 2) ? 2 : 0)
    ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic int lat_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic step();
    int idx;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (gnt[d] && reset_n && (d == cur_d)) begin
        q.push_back('{d: d, cyc: cyc + lat_of(d), err: pend_err, rd: pend_rd});
        saw_gnt = 1'b1;
      end
      if (valid[d]) begin
        vseen[d]++;
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].d == d && idx < 0) idx = i;
        end
        if (idx < 0) begin
          check($sformatf("unexpected_valid_dut%0d", d), 32'd1, 32'd0);
        end else begin
          check($sformatf("resp_cycle_dut%0d", d), 32'(cyc), 32'(q[idx].cyc));
          check($sformatf("resp_err_dut%0d", d), {31'd0, error[d]}, {31'd0, q[idx].err});
          check($sformatf("resp_rdata_dut%0d", d), rdata[d], q[idx].rd);
          q.delete(idx);
        end
      end
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        check($sformatf("missing_valid_dut%0d", q[i].d), 32'd0, 32'd1);
        q.delete(i);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic e_err, input logic [31:0] e_rd,
                       output int waited);
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    cur_d    = d;
    pend_err = e_err;
    pend_rd  = e_rd;
    req[d]   = 1'b1;
    wr[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    be[d]    = b;
    saw_gnt  = 1'b0;
    waited   = 0;
    while (!saw_gnt && waited < 20) begin
      step();
      waited++;
    end
    if (!saw_gnt) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic add(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input logic e, input logic [31:0] rd);
    tbl.push_back('{d: d, wr: w, addr: a, wdata: wd, be: b, err: e, rd: rd});
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    int waited;
    int vs_before;
    n_chk   = 0;
    n_fail  = 0;
    cyc     = 0;
    cur_d   = -1;
    saw_gnt = 1'b0;
    pend_err = 1'b0;
    pend_rd  = 32'h0;
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'h0;
      vseen[d] = 0;
    end

    // LAT1: ordering, partial store, range/be errors, last word, low address bits ignored.
    add(0, 1, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0);
    add(0, 0, 32'h0001_0000, 32'h0,         4'hF, 0, 32'hDEAD_BEEF);
    add(0, 1, 32'h0001_0000, 32'h0000_AA00, 4'h2, 0, 32'h0);
    add(0, 0, 32'h0001_0000, 32'h0,         4'hF, 0, 32'hDEAD_AAEF);
    add(0, 0, 32'h0000_FFFC, 32'h0,         4'hF, 1, 32'h0);
    add(0, 1, 32'h0001_4000, 32'h1234_5678, 4'hF, 1, 32'h0);
    add(0, 1, 32'h0001_0000, 32'hCAFE_F00D, 4'h0, 1, 32'h0);
    add(0, 0, 32'h0001_0000, 32'h0,         4'h1, 0, 32'hDEAD_AAEF);
    add(0, 1, 32'h0001_3FFC, 32'h0102_0304, 4'hF, 0, 32'h0);
    add(0, 0, 32'h0001_3FFF, 32'h0,         4'hF, 0, 32'h0102_0304);
    add(0, 0, 32'hFFFF_FFFC, 32'h0,         4'hF, 1, 32'h0);
    // LAT3: four stores then four back-to-back loads.
    for (int i = 0; i < 4; i++) add(1, 1, 32'h0001_0000 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF, 0, 32'h0);
    for (int i = 0; i < 4; i++) add(1, 0, 32'h0001_0000 + 32'(4*i), 32'h0, 4'hF, 0, 32'hB000_0000 + 32'(i));
    // Stall 2: grant on the third cycle of each request.
    add(2, 1, 32'h0001_0000, 32'hC0C0_C0C0, 4'hF, 0, 32'h0);
    add(2, 0, 32'h0001_0000, 32'h0,         4'hF, 0, 32'hC0C0_C0C0);

    repeat (2) step();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_gnt_dut%0d", d),   {31'd0, gnt[d]},   32'd0);
      check($sformatf("reset_valid_dut%0d", d), {31'd0, valid[d]}, 32'd0);
      check($sformatf("reset_error_dut%0d", d), {31'd0, error[d]}, 32'd0);
      check($sformatf("reset_rdata_dut%0d", d), rdata[d],          32'd0);
    end
    reset_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      issue(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].err, tbl[i].rd, waited);
      check($sformatf("gnt_wait_vec%0d", i), 32'(waited), (tbl[i].d == 2) ? 32'd3 : 32'd1);
    end
    drain();
    check("queue_empty_after_table", 32'(q.size()), 32'd0);

    // Stall 2 with the request abandoned after one cycle.
    cur_d = 2; pend_err = 1'b0; pend_rd = 32'hC0C0_C0C0; saw_gnt = 1'b0;
    vs_before = vseen[2];
    req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h0001_0000; be[2] = 4'hF;
    step();
    req[2] = 1'b0;
    repeat (5) step();
    check("abort_no_gnt",   {31'd0, saw_gnt},             32'd0);
    check("abort_no_valid", 32'(vseen[2] - vs_before),    32'd0);
    issue(2, 0, 32'h0001_0000, 32'h0, 4'hF, 0, 32'hC0C0_C0C0, waited);
    check("abort_fresh_stall", 32'(waited), 32'd3);
    drain();

    // LAT3: reset with two loads in flight.
    issue(1, 0, 32'h0001_0000, 32'h0, 4'hF, 0, 32'hB000_0000, waited);
    issue(1, 0, 32'h0001_0004, 32'h0, 4'hF, 0, 32'hB000_0001, waited);
    req[1]  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_valid", {31'd0, valid[1]}, 32'd0);
    check("midreset_error", {31'd0, error[1]}, 32'd0);
    check("midreset_rdata", rdata[1],          32'd0);
    check("midreset_gnt",   {31'd0, gnt[1]},   32'd0);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].d == 1) q.delete(i);
    end
    vs_before = vseen[1];
    step();
    reset_n = 1'b1;
    repeat (6) step();
    check("no_valid_after_reset", 32'(vseen[1] - vs_before), 32'd0);
    issue(1, 0, 32'h0001_0004, 32'h0, 4'hF, 0, 32'hB000_0001, waited);
    issue(1, 0, 32'h0001_000C, 32'h0, 4'hF, 0, 32'hB000_0003, waited);
    drain();
    check("queue_empty_at_end", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
